// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing signals of uart_tx_fifo; slave is the buffer's view,
// master is the view of whatever drives pushes and the transmitter's busy line.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_overflow;
  logic          all_sent;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_busy,
    output full, almost_full, empty, count, overflow, all_sent, tx_start, tx_data
  );

  modport master (
    output wr_en, wr_data, clr_overflow, tx_busy,
    input  full, almost_full, empty, count, overflow, all_sent, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: push to tx_start is 2 edges, one launch per busy cycle.
// Pushes while full are dropped and flagged (sticky overflow); the launcher waits on tx_busy.
module uart_tx_fifo #(
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_ACK  = 2'd1,
    L_WAIT = 2'd2
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  state_e        state_q, state_d;

  logic full, empty, push, drop, pop;

  // Full is taken from registered count, so a same-cycle pop never makes room for a push.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = bus.wr_en & ~full;
    drop  = bus.wr_en & full;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = L_ACK;
        end
      end
      L_ACK: begin
        if (bus.tx_busy) state_d = L_WAIT;
      end
      L_WAIT: begin
        if (!bus.tx_busy) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped push outranks a clear in the same cycle.
    overflow_d = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= L_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.all_sent    = empty & (state_q == L_IDLE) & ~bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed launch/timing/reset sequences, a status vector table,
// and a randomized run scored against a queue model of the byte stream.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DEPTH            (DEPTH),
    .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy rises the cycle after tx_start is seen and lasts busy_len cycles.
  logic force_busy = 1'b0;
  int   busy_cnt;
  int   busy_len   = 3;
  assign bus.tx_busy = force_busy | (busy_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             busy_cnt <= 0;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (bus.tx_start)  busy_cnt <= busy_len;
  end

  // Launch monitor: single-cycle pulses, and no relaunch before busy has risen and fallen.
  logic       prev_start, armed, seen_hi;
  logic [7:0] sent_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_start <= 1'b0;
      armed      <= 1'b1;
      seen_hi    <= 1'b0;
    end else begin
      prev_start <= bus.tx_start;
      if (bus.tx_start) begin
        chk("start_width", {31'd0, prev_start}, 32'd0);
        chk("start_armed", {31'd0, armed}, 32'd1);
        sent_q.push_back(bus.tx_data);
        armed   <= 1'b0;
        seen_hi <= 1'b0;
      end else if (bus.tx_busy) begin
        seen_hi <= 1'b1;
      end else if (seen_hi) begin
        armed   <= 1'b1;
        seen_hi <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic expect_sent(input string nm, input logic [7:0] exp [$]);
    chk({nm, "_n"}, sent_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), {24'd0, sent_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] mq[$];
    logic       ovf_m;
    int         fall_t, npulse;
    logic       pb, seen3, seen2;
    logic       wr, clr, accept, drop;
    logic [7:0] d, front;

    // Held busy: wr, data, clr -> count, full, empty, almost_full, overflow
    tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h66, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clr_overflow = 1'b0;

    // Reset state
    #12;
    chk("rst_empty",    bus.empty,       1);
    chk("rst_count",    bus.count,       0);
    chk("rst_full",     bus.full,        0);
    chk("rst_af",       bus.almost_full, 0);
    chk("rst_ovf",      bus.overflow,    0);
    chk("rst_start",    bus.tx_start,    0);
    chk("rst_txdata",   bus.tx_data,     0);
    chk("rst_all_sent", bus.all_sent,    1);
    rst_n = 1'b1;
    tick();

    // Single byte: count 1 after the push edge, pulse after the next edge
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    chk("t1_count1", bus.count,    1);
    chk("t1_early",  bus.tx_start, 0);
    tick();
    chk("t1_start",  bus.tx_start, 1);
    chk("t1_data",   bus.tx_data,  8'hA5);
    chk("t1_count0", bus.count,    0);
    tick();
    chk("t1_pulse_end", bus.tx_start, 0);
    repeat (8) tick();
    expect_sent("t1_sent", '{8'hA5});

    // Three bytes against a 20-cycle transmitter: relaunch 2 edges after busy falls
    sent_q.delete();
    busy_len = 20;
    fall_t = -1; npulse = 0; pb = bus.tx_busy;
    for (int t = 0; t < 100; t++) begin
      bus.wr_en   = (t < 3);
      bus.wr_data = 8'(t + 1);
      tick();
      if (pb && !bus.tx_busy) fall_t = t;
      if (bus.tx_start) begin
        npulse++;
        if (fall_t >= 0) chk("t2_gap", t - fall_t, 2);
      end
      pb = bus.tx_busy;
    end
    bus.wr_en = 1'b0;
    chk("t2_npulse", npulse, 3);
    expect_sent("t2_sent", '{8'h01, 8'h02, 8'h03});
    chk("t2_all_sent", bus.all_sent, 1);

    // Status table with the transmitter held busy
    sent_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.wr_en        = tbl[i].wr;
      bus.wr_data      = tbl[i].d;
      bus.clr_overflow = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_count", i), bus.count,       tbl[i].cnt);
      chk($sformatf("v%0d_full", i),  bus.full,        tbl[i].full);
      chk($sformatf("v%0d_empty", i), bus.empty,       tbl[i].empty);
      chk($sformatf("v%0d_af", i),    bus.almost_full, tbl[i].af);
      chk($sformatf("v%0d_ovf", i),   bus.overflow,    tbl[i].ovf);
      chk($sformatf("v%0d_start", i), bus.tx_start,    0);
      chk($sformatf("v%0d_alls", i),  bus.all_sent,    0);
    end
    bus.wr_en = 1'b0; bus.clr_overflow = 1'b0;

    // Drain after busy drops: almost_full tracks count through 3 and 2
    busy_len = 2; force_busy = 1'b0;
    seen3 = 1'b0; seen2 = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (bus.count == 3 && !seen3) begin seen3 = 1'b1; chk("t6_af_at3", bus.almost_full, 1); end
      if (bus.count == 2 && !seen2) begin seen2 = 1'b1; chk("t6_af_at2", bus.almost_full, 0); end
    end
    chk("t6_saw2", seen2, 1);
    chk("t3_empty", bus.empty, 1);
    expect_sent("t3_sent", '{8'h11, 8'h22, 8'h33, 8'h44});

    // Push on the same edge as a launcher pop: count stays 3
    sent_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'hAA + 8'(17 * i);
      tick();
    end
    bus.wr_data = 8'hDD; force_busy = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    chk("t4_count", bus.count,    3);
    chk("t4_start", bus.tx_start, 1);
    chk("t4_data",  bus.tx_data,  8'hAA);
    repeat (40) tick();
    expect_sent("t4_sent", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

    // Reset while in L_ACK with two bytes still queued
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h71 + 8'(i);
      tick();
    end
    bus.wr_en = 1'b0; force_busy = 1'b0;
    tick();
    chk("t5_pre_start", bus.tx_start, 1);
    chk("t5_pre_count", bus.count,    2);
    rst_n = 1'b0;
    #1;
    chk("t5_start", bus.tx_start, 0);
    chk("t5_count", bus.count,    0);
    chk("t5_empty", bus.empty,    1);
    tick();
    rst_n = 1'b1;
    sent_q.delete();
    repeat (30) tick();
    chk("t5_no_launch", sent_q.size(), 0);
    chk("t5_all_sent",  bus.all_sent,  1);

    // Randomized traffic against a queue model of accepted bytes
    ovf_m = 1'b0;
    for (int n = 0; n < 800; n++) begin
      wr  = ($urandom_range(0, 9) < ((n < 400) ? 6 : 3));
      d   = 8'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) force_busy = ~force_busy;
      busy_len = $urandom_range(1, 4);
      accept = wr && (mq.size() < DEPTH);
      drop   = wr && !accept;
      bus.wr_en = wr; bus.wr_data = d; bus.clr_overflow = clr;
      tick();
      if (bus.tx_start) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL rnd_launch got launch of %0h expected none (model empty)", bus.tx_data);
        end else begin
          front = mq.pop_front();
          if (bus.tx_data !== front) begin
            errors++;
            $display("FAIL rnd_data got %0h expected %0h", bus.tx_data, front);
          end
        end
      end
      if (accept) mq.push_back(d);
      ovf_m = drop ? 1'b1 : (clr ? 1'b0 : ovf_m);
      chk("rnd_count", bus.count,       mq.size());
      chk("rnd_full",  bus.full,        mq.size() == DEPTH);
      chk("rnd_empty", bus.empty,       mq.size() == 0);
      chk("rnd_af",    bus.almost_full, mq.size() >= AFL);
      chk("rnd_ovf",   bus.overflow,    ovf_m);
    end

    bus.wr_en = 1'b0; bus.clr_overflow = 1'b0; force_busy = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.tx_start) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL drain_launch got launch of %0h expected none (model empty)", bus.tx_data);
        end else begin
          front = mq.pop_front();
          if (bus.tx_data !== front) begin
            errors++;
            $display("FAIL drain_data got %0h expected %0h", bus.tx_data, front);
          end
        end
      end
      if (mq.size() == 0 && bus.all_sent) break;
    end
    chk("drain_model_empty", mq.size(),    0);
    chk("drain_all_sent",    bus.all_sent, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
